// File: rtl/fir_pkg.sv
// Shared types and width helpers for the FIR MAC sequencer.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MAC   = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam int DEF_LENGTH = 100;
  localparam int DEF_IDX_W  = $clog2(DEF_LENGTH);

  // Tap index width; kept at least 1 so a single-tap build still has a pointer bit.
  function automatic int idx_width(input int length);
    return (length > 1) ? $clog2(length) : 1;
  endfunction

  function automatic int acc_width(input int w, input int cw, input int length);
    return w + cw + $clog2(length);
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Signed multiply-accumulate: full-precision product, sign-extended into the
// accumulator, with synchronous clear and enable.
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int ACC_WIDTH = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [A_WIDTH-1:0]   a_i,
  input  logic signed [B_WIDTH-1:0]   b_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  logic signed [P_WIDTH-1:0]   prod_d;
  logic signed [ACC_WIDTH-1:0] prod_ext_d;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;

  always_comb begin
    prod_d     = a_i * b_i;
    prod_ext_d = {{(ACC_WIDTH - P_WIDTH){prod_d[P_WIDTH-1]}}, prod_d};
    acc_d      = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q + prod_ext_d;
  end

  always_ff @(posedge clk) begin
    if (rst)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_mac_sequencer.sv
// Sequences one sample through the FIR: shift into the register file, sweep all
// taps through the MAC, then hold the result on a valid/ready output.
//   state | meaning
//   IDLE  | ready for a new input sample
//   SHIFT | strobe shift_enb, clear accumulator and tap index
//   MAC   | accumulate tap k * coef k, k = 0 .. LENGTH-1
//   OUT   | present y_data until downstream accepts
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LENGTH     = 100,
  parameter int COEF_WIDTH = 8,
  parameter int ACC_WIDTH  = acc_width(WIDTH, COEF_WIDTH, LENGTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic signed [WIDTH-1:0]         in_data,
  output logic                            shift_enb,
  output logic signed [WIDTH-1:0]         sample_out,
  output logic [LENGTH-1:0]               pointer,
  input  logic signed [WIDTH-1:0]         tap_data,
  output logic [idx_width(LENGTH)-1:0]    coef_addr,
  input  logic signed [COEF_WIDTH-1:0]    coef_data,
  output logic                            y_valid,
  input  logic                            y_ready,
  output logic signed [ACC_WIDTH-1:0]     y_data
);

  localparam int            IW     = idx_width(LENGTH);
  localparam logic [IW-1:0] K_LAST = IW'(LENGTH - 1);

  state_e                  state_q;
  logic                    in_ready_q;
  logic                    shift_enb_q;
  logic                    y_valid_q;
  logic signed [WIDTH-1:0] sample_q;
  logic [IW-1:0]           k_q;
  logic                    acc_clr;
  logic                    acc_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      shift_enb_q <= 1'b0;
      y_valid_q   <= 1'b0;
      sample_q    <= '0;
      k_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sample_q    <= in_data;
            in_ready_q  <= 1'b0;
            shift_enb_q <= 1'b1;
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_enb_q <= 1'b0;
          k_q         <= '0;
          state_q     <= MAC;
        end
        MAC: begin
          if (k_q == K_LAST) begin
            y_valid_q <= 1'b1;
            state_q   <= OUT;
          end else begin
            k_q <= k_q + IW'(1);
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The accumulator is cleared in the shift cycle so MAC starts from zero on tap 0.
  assign acc_clr = (state_q == SHIFT);
  assign acc_en  = (state_q == MAC);

  fir_mac_unit #(
    .A_WIDTH  (WIDTH),
    .B_WIDTH  (COEF_WIDTH),
    .ACC_WIDTH(ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(acc_clr),
    .en_i (acc_en),
    .a_i  (tap_data),
    .b_i  (coef_data),
    .acc_o(y_data)
  );

  assign in_ready   = in_ready_q;
  assign shift_enb  = shift_enb_q;
  assign y_valid    = y_valid_q;
  assign sample_out = sample_q;
  assign coef_addr  = k_q;
  assign pointer    = {{(LENGTH - IW){1'b0}}, k_q};

endmodule

// File: doc/fir_mac_sequencer.md
# fir_mac_sequencer

Control and arithmetic stage directly downstream of the FIR shifting register file. Per accepted input sample it pulses the file's shift enable, sweeps the file's read pointer across all taps, multiplies each tap by its coefficient, accumulates, and presents one filtered output word over a valid/ready handshake. Together with the register file and a coefficient memory it forms the complete direct-form FIR.

## Interface
Parameters:
- WIDTH, 8, sample width (signed); matches register file WIDTH
- LENGTH, 100, tap count; matches register file LENGTH
- COEF_WIDTH, 8, coefficient width (signed)
- ACC_WIDTH, WIDTH+COEF_WIDTH+$clog2(LENGTH) (23 at defaults), accumulator/output width (signed)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  WIDTH  signed input sample
- shift_enb  out  1  one-cycle shift strobe to register file
- sample_out  out  WIDTH  sample driven to register file `in`
- pointer  out  LENGTH  tap index to register file (binary, zero-extended)
- tap_data  in  WIDTH  register file `out`, combinational on pointer
- coef_addr  out  $clog2(LENGTH)  coefficient memory address (equals tap index)
- coef_data  in  COEF_WIDTH  coefficient, combinational on coef_addr
- y_valid  out  1  filtered output valid
- y_ready  in  1  downstream accepts output
- y_data  out  ACC_WIDTH  signed filtered output

## Operation
- States: IDLE, SHIFT, MAC, OUT.
- IDLE: in_ready=1. in_valid&in_ready → latch in_data into sample register, go SHIFT.
- SHIFT: shift_enb=1 for exactly this cycle, sample_out=latched sample; accumulator cleared; tap index cleared to 0; go MAC.
- MAC: pointer=coef_addr=k; acc <= acc + tap_data*coef_data (full-precision signed product, sign-extended to ACC_WIDTH). k increments each cycle; after k=LENGTH-1 go OUT.
- OUT: y_valid=1, y_data=acc, held stable until y_ready. y_valid&y_ready → IDLE.
- Tap 0 during MAC is the sample just shifted in (newest); tap LENGTH-1 the oldest.
- No saturation: ACC_WIDTH is sized so no overflow is possible for any input/coef values.
- in_ready=0 in SHIFT, MAC, OUT; in_valid there is ignored, in_data not sampled.
- shift_enb is 0 in every state except SHIFT.
- sample_out holds the latched sample at all times (don't-care outside SHIFT but stable).

## Timing
- Reset values: in_ready=1 (state IDLE), shift_enb=0, sample_out=0, pointer=0, coef_addr=0, y_valid=0, y_data=0; accumulator and tap index 0.
- Accept at edge t → shift_enb high in cycle t+1 → MAC cycles t+2..t+1+LENGTH → y_valid high from cycle t+2+LENGTH.
- Minimum sample period LENGTH+3 cycles (accept, shift, LENGTH MAC, one OUT cycle with y_ready=1).
- y_ready low: remains in OUT indefinitely, y_data unchanged, no new sample accepted.
- rst during any state: next cycle IDLE with all reset values; partial result discarded, no y_valid. Register file shares rst and clears in the same cycle.
- rst has priority over any simultaneous handshake.

## Structure
- Shared package fir_pkg: state enum (IDLE/SHIFT/MAC/OUT), ACC_WIDTH derivation function, index-width constant ($clog2(LENGTH)).
- One sub-module: fir_mac_unit (signed multiply, sign-extend, accumulate with synchronous clear and enable); FSM, tap counter and handshake in top.

## Test plan
- Reset: assert rst 2 cycles mid-MAC → y_valid=0, in_ready=1, pointer=0 next cycle; following sample processed from cleared history.
- Impulse: coef[k]=k+1, feed 1 then 0s (LENGTH=100) → outputs 1,2,3,…,100 then 0; each y_valid exactly LENGTH+2 cycles after accept.
- Step: all coef=1, feed 100 samples of 5 → outputs 5,10,…,500; 101st output 500.
- Extremes: all coef=-128, 100 samples of -128 → final output 1,638,400, no wrap in 23 bits.
- Back-pressure: y_ready low 20 cycles in OUT → y_data stable, in_ready=0, in_valid pulses ignored, no extra shift_enb.
- Strobe check: over 10 samples shift_enb count = 10, each exactly one cycle, always immediately after an accept.
